// File: rtl/cla_multiword_sequencer.sv
// cla_multiword_sequencer
//   Adds two NBYTES-wide operands through one shared 8-bit carry-lookahead
//   adder, one byte per clock, least-significant byte first. The carry out of
//   each byte is registered and fed into the next byte's carry in.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        request, honoured only in IDLE or DONE
//   a, b, cin    operands and carry-in, captured on the accepting edge
//   busy         high while bytes are being added
//   done         one-cycle pulse; result, cout and ovf are valid
//   result       sum (bytes fill in progressively while busy)
//   cout         carry out of the most-significant byte
//   ovf          signed two's-complement overflow

module CarryLookaheadAdder (
   input  logic [7:0] X,
   input  logic [7:0] Y,
   input  logic       C0,
   output logic [7:0] sum,
   output logic       carry_out
);

   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;
   logic       acc;
   logic       prop;

   // Each carry is formed directly from generate/propagate terms and C0,
   // not rippled from the previous carry.
   always_comb begin
      g    = X & Y;
      p    = X ^ Y;
      c    = '0;
      acc  = 1'b0;
      prop = 1'b0;
      c[0] = C0;
      for (int i = 0; i < 8; i++) begin
         acc  = g[i];
         prop = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc  = acc | (prop & g[j]);
            prop = prop & p[j];
         end
         acc      = acc | (prop & C0);
         c[i + 1] = acc;
      end
      sum       = p ^ c[7:0];
      carry_out = c[8];
   end

endmodule

module cla_multiword_sequencer #(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned CNTW   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  cout,
   output logic                  ovf
);

   localparam int unsigned W = 8 * NBYTES;
   localparam logic [CNTW-1:0] LastIdx = CNTW'(NBYTES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StAdd,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            c_q, c_d;
   logic [CNTW-1:0] idx_q, idx_d;
   logic [W-1:0]    result_q, result_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [7:0]      cla_x;
   logic [7:0]      cla_y;
   logic [7:0]      cla_sum;
   logic            cla_carry;

   // Byte select by constant-index mux so no variable part-selects are needed.
   always_comb begin
      cla_x = '0;
      cla_y = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx_q == CNTW'(i)) begin
            cla_x = a_q[8*i +: 8];
            cla_y = b_q[8*i +: 8];
         end
      end
   end

   CarryLookaheadAdder u_cla (
      .X         (cla_x),
      .Y         (cla_y),
      .C0        (c_q),
      .sum       (cla_sum),
      .carry_out (cla_carry)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      idx_d    = idx_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               c_d     = cin;
               idx_d   = '0;
               state_d = StAdd;
            end else begin
               state_d = StIdle;
            end
         end
         StAdd: begin
            for (int i = 0; i < NBYTES; i++) begin
               if (idx_q == CNTW'(i)) begin
                  result_d[8*i +: 8] = cla_sum;
               end
            end
            c_d = cla_carry;
            if (idx_q == LastIdx) begin
               state_d = StDone;
               cout_d  = cla_carry;
               // On the last byte, cla_sum[7] is the result sign bit.
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_sum[7] != a_q[W-1]);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = (state_q == StAdd);
   assign done   = (state_q == StDone);
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
module tb_cla_multiword_sequencer;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   // Filled by issue_op.
   int lat;
   int overlap_cnt;
   int busy_gap_cnt;

   always #5 clk = ~clk;

   cla_multiword_sequencer #(.NBYTES(NBYTES), .CNTW(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   // Reference: plain wide arithmetic, signed range check for overflow.
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci);
      logic [W:0] u;
      longint     s;
      logic       v;
      u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      s = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return {v, u};
   endfunction

   // Launch one op, scramble inputs after the accepting edge, wait for done.
   task automatic issue_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      @(negedge clk);
      a = x; b = y; cin = ci; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
      lat = -1; overlap_cnt = 0; busy_gap_cnt = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (busy && done) overlap_cnt++;
         if (done) begin
            lat = n;
            break;
         end
         if (!busy) busy_gap_cnt++;
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({busy, done, result, cout, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b, need all 0",
                  busy, done, result, cout, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic ci);
      logic [W+1:0] exp;
      exp = ref_add(x, y, ci);
      issue_op(x, y, ci);
      total++;
      // Done appears NBYTES edges after the accepting edge (cycle NBYTES+1).
      if (lat !== NBYTES || overlap_cnt != 0 || busy_gap_cnt != 0) begin
         bad++;
         $display("FAIL %s_timing: got lat=%0d overlap=%0d busy_gaps=%0d, need lat=%0d 0 0",
                  name, lat, overlap_cnt, busy_gap_cnt, NBYTES);
      end
      total++;
      if ({ovf, cout, result} !== exp) begin
         bad++;
         $display("FAIL %s_value: a=%h b=%h cin=%b got result=%h cout=%b ovf=%b, need %h %b %b",
                  name, x, y, ci, result, cout, ovf, exp[W-1:0], exp[W], exp[W+1]);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [6] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0,
                               32'h80000000, 32'h7FFFFFFF};
      logic [W-1:0] vb [6] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h0,
                               32'h80000000, 32'h00000000};
      logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         run_and_check($sformatf("directed%0d", i), va[i], vb[i], vc[i]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         run_and_check($sformatf("random%0d", i), W'($urandom), W'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_ignore_start();
      logic [W+1:0] exp;
      int           dones;
      logic [W-1:0] seen;
      exp = ref_add(32'h01020304, 32'h10203040, 1'b0);
      @(negedge clk);
      a = 32'h01020304; b = 32'h10203040; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a = 32'hDEADBEEF; b = 32'h11111111; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      dones = 0;
      seen  = '0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            dones++;
            seen = result;
         end
      end
      total++;
      if (dones != 1) begin
         bad++;
         $display("FAIL ignore_start_pulses: got %0d done pulses, need 1", dones);
      end
      total++;
      if (seen !== exp[W-1:0]) begin
         bad++;
         $display("FAIL ignore_start_value: got %h, need %h", seen, exp[W-1:0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [W+1:0] e1, e2;
      logic [W-1:0] r1;
      int           l1, l2;
      e1 = ref_add(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0);
      e2 = ref_add(32'h0000FFFF, 32'h00000001, 1'b1);
      @(negedge clk);
      a = 32'hA5A5A5A5; b = 32'h5A5A5A5B; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      a = 32'h0000FFFF; b = 32'h00000001; cin = 1'b1;
      l1 = -1;
      r1 = '0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            l1 = n;
            r1 = result;
            break;
         end
      end
      l2 = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) start = 1'b0;
         if (done) begin
            l2 = n;
            break;
         end
      end
      total++;
      if (l1 != NBYTES || r1 !== e1[W-1:0]) begin
         bad++;
         $display("FAIL b2b_first: got lat=%0d result=%h, need lat=%0d result=%h",
                  l1, r1, NBYTES, e1[W-1:0]);
      end
      total++;
      if (l2 != NBYTES + 1 || {ovf, cout, result} !== e2) begin
         bad++;
         $display("FAIL b2b_second: got gap=%0d result=%h cout=%b ovf=%b, need gap=%0d %h %b %b",
                  l2, result, cout, ovf, NBYTES + 1, e2[W-1:0], e2[W], e2[W+1]);
      end
   endtask

   task automatic test_accumulate();
      logic [W-1:0] acc;
      int           errs;
      acc  = '0;
      errs = 0;
      for (int i = 0; i < 200; i++) begin
         issue_op(32'h1, acc, 1'b0);
         acc = acc + 1;
         total++;
         if (lat != NBYTES || result !== acc || cout !== 1'b0) begin
            bad++;
            errs++;
            if (errs < 5)
               $display("FAIL accumulate_%0d: got lat=%0d result=%h cout=%b, need %0d %h 0",
                        i, lat, result, cout, NBYTES, acc);
         end
         acc = result;
      end
      total++;
      if (result !== 32'd200) begin
         bad++;
         $display("FAIL accumulate_final: got %h, need 000000c8", result);
      end
   endtask

   task automatic test_reset_mid();
      logic [W+1:0] exp;
      @(negedge clk);
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++;
      if ({busy, done, result, cout, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_mid_add: got busy=%b done=%b result=%h cout=%b ovf=%b, need all 0",
                  busy, done, result, cout, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      exp = ref_add(32'h12345678, 32'h11111111, 1'b0);
      run_and_check("after_reset", 32'h12345678, 32'h11111111, 1'b0);
      total++;
      if (result !== exp[W-1:0] || cout !== 1'b0) begin
         bad++;
         $display("FAIL after_reset_sum: got %h cout=%b, need %h 0", result, cout, exp[W-1:0]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_accumulate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cla_multiword_sequencer.md
Name: cla_multiword_sequencer

Overview:
- Sequences one 8-bit CarryLookaheadAdder instance (ports X, Y, C0, sum, carry_out) to add two NBYTES-wide operands, one byte per clock, least-significant byte first.
- Latches operands on a start handshake, chains carry_out of each byte into C0 of the next, and presents the full result with a one-cycle done pulse.
- Sits between a requesting datapath and the shared 8-bit adder; the adder is instantiated inside this block.

Parameters:
- NBYTES, 4, number of 8-bit limbs per operand; legal range 2..16.
- CNTW, 4, width of the byte-index counter; must satisfy 2^CNTW >= NBYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  8*NBYTES  operand A; sampled on the accepting edge.
- b  input  8*NBYTES  operand B; sampled on the accepting edge.
- cin  input  1  carry into byte 0; sampled on the accepting edge.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse; result, cout and ovf are valid.
- result  output  8*NBYTES  sum.
- cout  output  1  carry out of the most-significant byte.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; byte index=0; operand and carry registers=0.
- States and transitions:
  - IDLE: start=1 at an edge latches a, b and cin into carry register c, sets idx=0, and moves to ADD.
  - ADD: every edge writes result[8*idx+:8]=cla.sum and c=cla.carry_out, then increments idx. The edge at idx==NBYTES-1 moves to DONE instead of incrementing further.
  - DONE: lasts exactly one cycle with done=1. Next edge goes to ADD if start=1 (new accept, same rules as IDLE), otherwise to IDLE.
- Adder hookup (combinational): X=A_reg[8*idx+:8], Y=B_reg[8*idx+:8], C0=c.
- Latency: start accepted at edge k. busy=1 from after edge k to after edge k+NBYTES. done=1 for the cycle following edge k+NBYTES. Total is NBYTES+1 cycles from accept to done.
- Register updates at the final ADD edge:
  - cout=carry_out.
  - ovf=(A_msb==B_msb)&&(sum_msb!=A_msb), where msb is bit 8*NBYTES-1.
- result, cout and ovf hold their values after DONE until the next accept overwrites them. result bytes change progressively during ADD.
- start while busy=1 is ignored, not queued.
- Operands a, b and cin may change freely after the accepting edge.
- Arithmetic is modulo 2^(8*NBYTES); the carry beyond the top byte appears only on cout.
- Reset asserted mid-ADD aborts immediately. No done pulse follows, and outputs clear to reset values.
- done and busy are never high in the same cycle.

Test Plan:
- NBYTES=4, cin=0: a=0x000000FF, b=0x00000001 -> done 5 cycles after accept; result=0x00000100, cout=0, ovf=0.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> result=0x00000000, cout=1, ovf=0. Also a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, cout=0, ovf=1.
- a=0, b=0, cin=1 -> result=0x00000001, cout=0. Also a=0x80000000, b=0x80000000 -> result=0, cout=1, ovf=1.
- Start pulsed again 2 cycles after accept with different operands -> ignored; first sum reported, exactly one done pulse. Start held high through DONE -> back-to-back op accepted, second done 5 cycles after first.
- Accumulate chain: a=1, b=previous result, 200 iterations from 0 -> final result=200 (0x000000C8), cout=0 throughout.
- Assert rst during ADD at idx=2 -> busy=0, done=0, result=0 within the same cycle. Next op (0x12345678+0x11111111) -> 0x23456789, cout=0.
